usb_slave_endp_mux: RTL and testbench

USB_SLAVE_ENDP_MUX -- requirements
Module: usb_slave_endp_mux

---
 rtl/usb_slave_endp_mux.sv | 114 +++++++++++
 tb/tb_usb_slave_endp_mux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_slave_endp_mux.sv
// Endpoint multiplexer for a USB slave controller. It routes the selected endpoint's
// control, FIFO and status signals, and keeps per-endpoint byte counters.
module usb_slave_endp_mux #(
  parameter int NUM_EP = 4,
  parameter int CNT_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              currEndP,
  input  logic [NUM_EP*5-1:0]     epCtrlFlat,
  output logic [4:0]              endPControlReg,
  input  logic                    NAKSent,
  input  logic                    stallSent,
  input  logic                    CRCError,
  input  logic                    bitStuffError,
  input  logic                    RxOverflow,
  input  logic                    RxTimeOut,
  input  logic                    dataSequence,
  input  logic                    ACKRxed,
  input  logic                    endPMuxErrorsWEn,
  input  logic                    clrEPRdy,
  output logic [NUM_EP*8-1:0]     epStatusFlat,
  output logic [NUM_EP-1:0]       clrRdyVec,
  input  logic                    TxFifoREn,
  output logic [7:0]              TxFifoData,
  output logic                    TxFifoEmpty,
  output logic [NUM_EP-1:0]       TxFifoEPREn,
  input  logic [NUM_EP*8-1:0]     TxFifoEPData,
  input  logic [NUM_EP-1:0]       TxFifoEPEmpty,
  input  logic                    RxFifoWEn,
  output logic                    RxFifoFull,
  output logic [NUM_EP-1:0]       RxFifoEPWEn,
  input  logic [NUM_EP-1:0]       RxFifoEPFull,
  output logic [NUM_EP*CNT_W-1:0] epByteCntFlat
);

  localparam logic [4:0]       NUM_EP_L = 5'(NUM_EP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic              sel;
  logic [NUM_EP-1:0] hit;
  logic [7:0]        status_in;
  logic [4:0]        ctrl_mux;
  logic [7:0]        data_mux;
  logic              empty_mux;
  logic              full_mux;

  assign sel = {1'b0, currEndP} < NUM_EP_L;
  assign status_in = {dataSequence, ACKRxed, stallSent, NAKSent,
                      RxOverflow, bitStuffError, CRCError, RxTimeOut};

  // hit is one-hot (or all zero when out of range), so OR-ing acts as the mux
  always_comb begin
    ctrl_mux  = '0;
    data_mux  = '0;
    empty_mux = 1'b0;
    full_mux  = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (hit[i]) begin
        ctrl_mux  = ctrl_mux | epCtrlFlat[i*5 +: 5];
        data_mux  = data_mux | TxFifoEPData[i*8 +: 8];
        empty_mux = empty_mux | TxFifoEPEmpty[i];
        full_mux  = full_mux | RxFifoEPFull[i];
      end
    end
  end

  assign endPControlReg = ctrl_mux;
  assign TxFifoData     = data_mux;
  assign TxFifoEmpty    = ~sel | empty_mux;
  assign RxFifoFull     = ~sel | full_mux;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EP; gi++) begin : g_ep
      logic [7:0]       status_reg;
      logic [CNT_W-1:0] run_reg;
      logic [CNT_W-1:0] run_next;
      logic [CNT_W-1:0] byte_cnt_reg;
      logic             clr_reg;

      assign hit[gi]         = sel && (currEndP == 4'(gi));
      assign TxFifoEPREn[gi] = hit[gi] & TxFifoREn & ~TxFifoEPEmpty[gi];
      assign RxFifoEPWEn[gi] = hit[gi] & RxFifoWEn & ~RxFifoEPFull[gi];

      // a simultaneous read and write still counts as a single byte
      assign run_next = ((TxFifoEPREn[gi] | RxFifoEPWEn[gi]) && (run_reg != CNT_MAX))
                        ? run_reg + CNT_W'(1) : run_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          status_reg   <= '0;
          run_reg      <= '0;
          byte_cnt_reg <= '0;
          clr_reg      <= 1'b0;
        end else begin
          clr_reg <= hit[gi] & clrEPRdy;
          if (hit[gi] && endPMuxErrorsWEn) begin
            status_reg   <= status_in;
            byte_cnt_reg <= run_next;
            run_reg      <= '0;
          end else begin
            run_reg <= run_next;
          end
        end
      end

      assign epStatusFlat[gi*8 +: 8]         = status_reg;
      assign epByteCntFlat[gi*CNT_W +: CNT_W] = byte_cnt_reg;
      assign clrRdyVec[gi]                    = clr_reg;
    end
  endgenerate

endmodule

// File: tb/tb_usb_slave_endp_mux.sv
// Randomized bench for usb_slave_endp_mux, checked against a per-endpoint array model.
// The directed sequences cover mux, capture, counting, saturation, range and reset.
module tb_usb_slave_endp_mux;

  localparam int NEP  = 4;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] currEndP;
  logic [NEP*5-1:0] epCtrlFlat;
  logic [4:0] endPControlReg;
  logic NAKSent, stallSent, CRCError, bitStuffError, RxOverflow, RxTimeOut, dataSequence, ACKRxed;
  logic endPMuxErrorsWEn, clrEPRdy;
  logic [NEP*8-1:0] epStatusFlat;
  logic [NEP-1:0] clrRdyVec;
  logic TxFifoREn;
  logic [7:0] TxFifoData;
  logic TxFifoEmpty;
  logic [NEP-1:0] TxFifoEPREn;
  logic [NEP*8-1:0] TxFifoEPData;
  logic [NEP-1:0] TxFifoEPEmpty;
  logic RxFifoWEn;
  logic RxFifoFull;
  logic [NEP-1:0] RxFifoEPWEn;
  logic [NEP-1:0] RxFifoEPFull;
  logic [NEP*CW-1:0] epByteCntFlat;

  logic [4:0] ep_ctrl [NEP];
  logic [7:0] tx_data [NEP];

  logic [7:0]     m_status [NEP];
  int             m_run [NEP];
  int             m_cnt [NEP];
  logic [NEP-1:0] m_clr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    epCtrlFlat   = '0;
    TxFifoEPData = '0;
    for (int i = 0; i < NEP; i++) begin
      epCtrlFlat[i*5 +: 5]   = ep_ctrl[i];
      TxFifoEPData[i*8 +: 8] = tx_data[i];
    end
  end

  usb_slave_endp_mux #(.NUM_EP(NEP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .currEndP(currEndP), .epCtrlFlat(epCtrlFlat),
    .endPControlReg(endPControlReg), .NAKSent(NAKSent), .stallSent(stallSent),
    .CRCError(CRCError), .bitStuffError(bitStuffError), .RxOverflow(RxOverflow),
    .RxTimeOut(RxTimeOut), .dataSequence(dataSequence), .ACKRxed(ACKRxed),
    .endPMuxErrorsWEn(endPMuxErrorsWEn), .clrEPRdy(clrEPRdy),
    .epStatusFlat(epStatusFlat), .clrRdyVec(clrRdyVec), .TxFifoREn(TxFifoREn),
    .TxFifoData(TxFifoData), .TxFifoEmpty(TxFifoEmpty), .TxFifoEPREn(TxFifoEPREn),
    .TxFifoEPData(TxFifoEPData), .TxFifoEPEmpty(TxFifoEPEmpty), .RxFifoWEn(RxFifoWEn),
    .RxFifoFull(RxFifoFull), .RxFifoEPWEn(RxFifoEPWEn), .RxFifoEPFull(RxFifoEPFull),
    .epByteCntFlat(epByteCntFlat)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NEP; i++) begin
      m_status[i] = '0;
      m_run[i]    = 0;
      m_cnt[i]    = 0;
    end
    m_clr = '0;
  endtask

  task automatic idle_inputs();
    currEndP = 4'd0;
    {NAKSent, stallSent, CRCError, bitStuffError, RxOverflow, RxTimeOut, dataSequence, ACKRxed} = '0;
    endPMuxErrorsWEn = 1'b0;
    clrEPRdy         = 1'b0;
    TxFifoREn        = 1'b0;
    RxFifoWEn        = 1'b0;
    TxFifoEPEmpty    = '0;
    RxFifoEPFull     = '0;
    for (int i = 0; i < NEP; i++) begin
      ep_ctrl[i] = 5'(i + 1);
      tx_data[i] = 8'(8'h10 * (i + 1));
    end
  endtask

  task automatic random_inputs();
    currEndP = 4'($urandom_range(0, 5));
    {NAKSent, stallSent, CRCError, bitStuffError, RxOverflow, RxTimeOut, dataSequence, ACKRxed} = 8'($urandom);
    endPMuxErrorsWEn = ($urandom_range(0, 3) == 0);
    clrEPRdy         = ($urandom_range(0, 2) == 0);
    TxFifoREn        = 1'($urandom);
    RxFifoWEn        = 1'($urandom);
    TxFifoEPEmpty    = NEP'($urandom);
    RxFifoEPFull     = NEP'($urandom);
    for (int i = 0; i < NEP; i++) begin
      ep_ctrl[i] = 5'($urandom);
      tx_data[i] = 8'($urandom);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [NEP*8-1:0]  es;
    logic [NEP*CW-1:0] ec;
    for (int i = 0; i < NEP; i++) begin
      es[i*8 +: 8]   = m_status[i];
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    check_val({tag, "_status"}, epStatusFlat, es);
    check_val({tag, "_bytecnt"}, epByteCntFlat, ec);
    check_val({tag, "_clrrdy"}, clrRdyVec, m_clr);
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic cycle();
    int             idx;
    bit             in_rng;
    logic [4:0]     e_ctrl;
    logic [7:0]     e_data;
    logic           e_empty, e_full;
    logic [NEP-1:0] e_tx, e_rx;
    #1;
    idx     = int'(currEndP);
    in_rng  = (idx < NEP);
    e_ctrl  = '0;
    e_data  = '0;
    e_empty = 1'b1;
    e_full  = 1'b1;
    e_tx    = '0;
    e_rx    = '0;
    if (in_rng) begin
      e_ctrl  = ep_ctrl[idx];
      e_data  = tx_data[idx];
      e_empty = TxFifoEPEmpty[idx];
      e_full  = RxFifoEPFull[idx];
      if (TxFifoREn && !e_empty) e_tx[idx] = 1'b1;
      if (RxFifoWEn && !e_full)  e_rx[idx] = 1'b1;
    end
    check_val("ctrl", endPControlReg, e_ctrl);
    check_val("txdata", TxFifoData, e_data);
    check_val("txempty", TxFifoEmpty, e_empty);
    check_val("rxfull", RxFifoFull, e_full);
    check_val("txren", TxFifoEPREn, e_tx);
    check_val("rxwen", RxFifoEPWEn, e_rx);
    m_clr = '0;
    if (in_rng) begin
      if (e_tx[idx] || e_rx[idx]) m_run[idx] = (m_run[idx] < MAXC) ? m_run[idx] + 1 : MAXC;
      if (endPMuxErrorsWEn) begin
        m_status[idx] = {dataSequence, ACKRxed, stallSent, NAKSent,
                         RxOverflow, bitStuffError, CRCError, RxTimeOut};
        m_cnt[idx]    = m_run[idx];
        m_run[idx]    = 0;
      end
      if (clrEPRdy) m_clr[idx] = 1'b1;
    end
    $display("txn ep=%0d txren=%b rxwen=%b we=%b clr=%b", idx, e_tx, e_rx, endPMuxErrorsWEn, clrEPRdy);
    @(posedge clk);
    @(negedge clk);
    check_regs("reg");
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #2 rst = 1'b0;
    #1 check_regs("reset");
    @(negedge clk);
    rst = 1'b1;

    // mux and read gating on EP2
    idle_inputs();
    currEndP  = 4'd2;
    tx_data[2] = 8'hA5;
    TxFifoREn = 1'b1;
    #1;
    check_val("mux_data", TxFifoData, 8'hA5);
    check_val("mux_ren", TxFifoEPREn, 4'b0100);
    cycle();
    TxFifoEPEmpty[2] = 1'b1;
    #1;
    check_val("mux_ren_empty", TxFifoEPREn, 4'b0000);
    check_val("mux_empty", TxFifoEmpty, 1'b1);
    cycle();

    // status capture on EP1
    idle_inputs();
    currEndP         = 4'd1;
    CRCError         = 1'b1;
    NAKSent          = 1'b1;
    endPMuxErrorsWEn = 1'b1;
    cycle();
    check_val("cap_ep1", epStatusFlat[15:8], 8'h12);
    check_val("cap_ep0", epStatusFlat[7:0], 8'h00);
    check_val("cap_ep2", epStatusFlat[23:16], 8'h00);
    check_val("cap_ep3", epStatusFlat[31:24], 8'h00);

    // byte count on EP3: 7 writes, one blocked, then strobe with an 8th write
    idle_inputs();
    currEndP  = 4'd3;
    RxFifoWEn = 1'b1;
    repeat (7) cycle();
    RxFifoEPFull[3] = 1'b1;
    cycle();
    RxFifoEPFull[3]  = 1'b0;
    endPMuxErrorsWEn = 1'b1;
    cycle();
    check_val("cnt_ep3", epByteCntFlat[15:12], 4'd8);
    RxFifoWEn = 1'b0;
    cycle();
    check_val("cnt_ep3_cleared", epByteCntFlat[15:12], 4'd0);

    // saturation on EP0
    idle_inputs();
    TxFifoREn = 1'b1;
    repeat (20) cycle();
    TxFifoREn        = 1'b0;
    endPMuxErrorsWEn = 1'b1;
    cycle();
    check_val("sat_ep0", epByteCntFlat[3:0], 4'd15);

    // out-of-range index with everything asserted
    idle_inputs();
    currEndP = 4'd6;
    {NAKSent, stallSent, CRCError, bitStuffError, RxOverflow, RxTimeOut, dataSequence, ACKRxed} = '1;
    endPMuxErrorsWEn = 1'b1;
    clrEPRdy         = 1'b1;
    TxFifoREn        = 1'b1;
    RxFifoWEn        = 1'b1;
    for (int i = 0; i < NEP; i++) ep_ctrl[i] = 5'h1F;
    #1;
    check_val("oor_ren", TxFifoEPREn, 4'b0000);
    check_val("oor_wen", RxFifoEPWEn, 4'b0000);
    check_val("oor_empty", TxFifoEmpty, 1'b1);
    check_val("oor_full", RxFifoFull, 1'b1);
    check_val("oor_ctrl", endPControlReg, 5'd0);
    cycle();
    check_val("oor_clr", clrRdyVec, 4'b0000);

    repeat (300) begin
      random_inputs();
      cycle();
    end

    // async reset with a clear-ready pulse in flight
    idle_inputs();
    currEndP         = 4'd1;
    clrEPRdy         = 1'b1;
    TxFifoREn        = 1'b1;
    NAKSent          = 1'b1;
    endPMuxErrorsWEn = 1'b1;
    cycle();
    endPMuxErrorsWEn = 1'b0;
    clrEPRdy         = 1'b0;
    cycle();
    clrEPRdy = 1'b1;
    cycle();
    check_val("pre_rst_clr", clrRdyVec, 4'b0010);
    rst = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    check_val("rst_comb", TxFifoEPREn, 4'b0010);
    rst      = 1'b1;
    clrEPRdy = 1'b0;

    // counting restarts from zero after reset
    repeat (3) cycle();
    TxFifoREn        = 1'b0;
    endPMuxErrorsWEn = 1'b1;
    cycle();
    check_val("post_rst_cnt", epByteCntFlat[7:4], 4'd3);

    repeat (200) begin
      random_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
